// File: rtl/wb_i2c_sequencer.sv
// Wishbone master that steps the IICMB I2C core (CSR/DPR/CMDR/FSMR) through complete transfers.
// One request at a time: write bytes stream in, read bytes stream out, one status word per request.
module wb_i2c_sequencer #(
  parameter int LEN_W   = 8,
  parameter int BUS_ID  = 0,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_rd_i,
  input  logic [6:0]       req_addr_i,
  input  logic [LEN_W-1:0] req_len_i,
  input  logic             wdat_valid_i,
  output logic             wdat_ready_o,
  input  logic [7:0]       wdat_i,
  output logic             rdat_valid_o,
  output logic [7:0]       rdat_o,
  output logic             rdat_last_o,
  output logic             rsp_valid_o,
  output logic [2:0]       rsp_status_o,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic             wb_we_o,
  output logic [1:0]       wb_adr_o,
  output logic [7:0]       wb_dat_o,
  input  logic [7:0]       wb_dat_i,
  input  logic             wb_ack_i,
  input  logic             irq_i
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] A_CSR  = 2'd0;
  localparam logic [1:0] A_DPR  = 2'd1;
  localparam logic [1:0] A_CMDR = 2'd2;

  localparam logic [2:0] ST_OK     = 3'd0;
  localparam logic [2:0] ST_NAK    = 3'd1;
  localparam logic [2:0] ST_AL     = 3'd2;
  localparam logic [2:0] ST_ERR    = 3'd3;
  localparam logic [2:0] ST_TO     = 3'd4;
  localparam logic [2:0] ST_BADLEN = 3'd5;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_ISSUE, S_WDAT, S_BUS, S_WAIT, S_DECODE, S_RSP
  } state_t;

  typedef enum logic [3:0] {
    P_CSR, P_BUS_DPR, P_BUS_CMD, P_START, P_ADDR_DPR, P_ADDR_CMD,
    P_WDAT, P_WCMD, P_RCMD, P_RDPR, P_STOP
  } step_t;

  state_t           state;
  step_t            step;
  logic             active;
  logic             rd_q;
  logic [6:0]       addr_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [TMR_W-1:0] tmr;
  logic [2:0]       status;
  logic [2:0]       flags;   // {NAK, AL, ERR} from the CMDR readback
  logic [LEN_W-1:0] cnt_nxt;
  logic             last_byte;

  assign cnt_nxt      = cnt + 1'b1;
  assign last_byte    = (cnt_nxt == len_q);
  assign req_ready_o  = (state == S_IDLE) && !rsp_valid_o;
  assign wdat_ready_o = (state == S_WDAT) && wdat_valid_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= S_INIT;
      step         <= P_CSR;
      active       <= 1'b0;
      rd_q         <= 1'b0;
      addr_q       <= '0;
      len_q        <= '0;
      cnt          <= '0;
      tmr          <= '0;
      status       <= ST_OK;
      flags        <= '0;
      rdat_valid_o <= 1'b0;
      rdat_o       <= '0;
      rdat_last_o  <= 1'b0;
      rsp_valid_o  <= 1'b0;
      rsp_status_o <= '0;
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_adr_o     <= '0;
      wb_dat_o     <= '0;
    end else begin
      rdat_valid_o <= 1'b0;
      rdat_last_o  <= 1'b0;
      rsp_valid_o  <= 1'b0;
      case (state)
        S_INIT: begin
          step  <= P_CSR;
          state <= S_ISSUE;
        end
        S_IDLE: begin
          if (req_valid_i && req_ready_o) begin
            rd_q   <= req_rd_i;
            addr_q <= req_addr_i;
            len_q  <= req_len_i;
            cnt    <= '0;
            status <= ST_OK;
            if (req_len_i == '0) begin
              rsp_valid_o  <= 1'b1;
              rsp_status_o <= ST_BADLEN;
            end else begin
              active <= 1'b1;
              step   <= P_BUS_DPR;
              state  <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          wb_we_o  <= 1'b1;
          wb_adr_o <= A_CMDR;
          wb_dat_o <= 8'h00;
          state    <= S_BUS;
          case (step)
            P_CSR:      begin wb_adr_o <= A_CSR; wb_dat_o <= 8'hC0; end
            P_BUS_DPR:  begin wb_adr_o <= A_DPR; wb_dat_o <= 8'(BUS_ID); end
            P_BUS_CMD:  wb_dat_o <= 8'h06;
            P_START:    wb_dat_o <= 8'h04;
            P_ADDR_DPR: begin wb_adr_o <= A_DPR; wb_dat_o <= {addr_q, rd_q}; end
            P_ADDR_CMD: wb_dat_o <= 8'h01;
            P_WCMD:     wb_dat_o <= 8'h01;
            P_RCMD:     wb_dat_o <= last_byte ? 8'h03 : 8'h02;
            P_RDPR:     begin wb_we_o <= 1'b0; wb_adr_o <= A_DPR; end
            P_STOP:     wb_dat_o <= 8'h05;
            default:    wb_dat_o <= 8'h05;
          endcase
        end
        S_WDAT: begin
          if (wdat_valid_i) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= 1'b1;
            wb_adr_o <= A_DPR;
            wb_dat_o <= wdat_i;
            state    <= S_BUS;
          end
        end
        S_BUS: begin
          if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            if (wb_we_o && wb_adr_o == A_CMDR) begin
              tmr   <= TMR_W'(TIMEOUT - 1);
              state <= S_WAIT;
            end else if (wb_we_o && wb_adr_o == A_CSR) begin
              state <= active ? S_RSP : S_IDLE;
            end else if (wb_we_o) begin
              case (step)
                P_BUS_DPR:  step <= P_BUS_CMD;
                P_ADDR_DPR: step <= P_ADDR_CMD;
                default:    step <= P_WCMD;
              endcase
              state <= S_ISSUE;
            end else if (wb_adr_o == A_CMDR) begin
              flags <= wb_dat_i[6:4];
              state <= S_DECODE;
            end else begin
              rdat_o       <= wb_dat_i;
              rdat_valid_o <= 1'b1;
              rdat_last_o  <= last_byte;
              cnt          <= cnt_nxt;
              step         <= last_byte ? P_STOP : P_RCMD;
              state        <= S_ISSUE;
            end
          end
        end
        S_WAIT: begin
          // irq takes precedence over an expiring timer on the same cycle
          if (irq_i) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= 1'b0;
            wb_adr_o <= A_CMDR;
            state    <= S_BUS;
          end else if (tmr == '0) begin
            status <= ST_TO;
            step   <= P_CSR;
            state  <= S_ISSUE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_DECODE: begin
          if (flags[1]) begin
            if (status == ST_OK) status <= ST_AL;
            state <= S_RSP;
          end else if (flags[0]) begin
            if (status == ST_OK) status <= ST_ERR;
            if (step == P_STOP) begin
              state <= S_RSP;
            end else begin
              step  <= P_STOP;
              state <= S_ISSUE;
            end
          end else if (flags[2] && (step == P_ADDR_CMD || step == P_WCMD)) begin
            status <= ST_NAK;
            step   <= P_STOP;
            state  <= S_ISSUE;
          end else begin
            case (step)
              P_BUS_CMD: begin step <= P_START;    state <= S_ISSUE; end
              P_START:   begin step <= P_ADDR_DPR; state <= S_ISSUE; end
              P_ADDR_CMD: begin
                if (rd_q) begin
                  step  <= P_RCMD;
                  state <= S_ISSUE;
                end else begin
                  step  <= P_WDAT;
                  state <= S_WDAT;
                end
              end
              P_WCMD: begin
                cnt <= cnt_nxt;
                if (last_byte) begin
                  step  <= P_STOP;
                  state <= S_ISSUE;
                end else begin
                  step  <= P_WDAT;
                  state <= S_WDAT;
                end
              end
              P_RCMD:  begin step <= P_RDPR; state <= S_ISSUE; end
              default: state <= S_RSP;
            endcase
          end
        end
        S_RSP: begin
          rsp_valid_o  <= 1'b1;
          rsp_status_o <= status;
          active       <= 1'b0;
          state        <= S_IDLE;
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_i2c_sequencer.sv
// Directed bench for wb_i2c_sequencer: a small IICMB-like Wishbone slave plus hand-derived
// register-write sequences, read bytes and status words for each transfer scenario.
`timescale 1ns/1ps
module tb_wb_i2c_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rd = 1'b0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_len = '0;
  logic       wdat_valid = 1'b0;
  logic       wdat_ready;
  logic [7:0] wdat = '0;
  logic       rdat_valid, rdat_last;
  logic [7:0] rdat;
  logic       rsp_valid;
  logic [2:0] rsp_status;
  logic       wb_cyc, wb_stb, wb_we;
  logic [1:0] wb_adr;
  logic [7:0] wb_wdat;
  logic [7:0] wb_rdat;
  logic       wb_ack, irq;

  always #5 clk = ~clk;

  wb_i2c_sequencer #(.LEN_W(8), .BUS_ID(0), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_rd_i(req_rd),
    .req_addr_i(req_addr), .req_len_i(req_len),
    .wdat_valid_i(wdat_valid), .wdat_ready_o(wdat_ready), .wdat_i(wdat),
    .rdat_valid_o(rdat_valid), .rdat_o(rdat), .rdat_last_o(rdat_last),
    .rsp_valid_o(rsp_valid), .rsp_status_o(rsp_status),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_adr_o(wb_adr),
    .wb_dat_o(wb_wdat), .wb_dat_i(wb_rdat), .wb_ack_i(wb_ack), .irq_i(irq)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // core model: ack one cycle after strobe, irq three cycles after each CMDR write
  logic [7:0] fault_cmd = 8'hFF;
  logic [7:0] fault_val = 8'h80;
  logic       irq_en = 1'b1;
  logic [7:0] last_cmd;
  int         irq_dly;
  int         cyc_n = 0;
  int         t_cmd = 0;
  logic [7:0] rdq[$];
  logic [9:0] wlog[$];

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack   <= 1'b0;
      irq      <= 1'b0;
      irq_dly  <= 0;
      wb_rdat  <= '0;
      last_cmd <= '0;
    end else begin
      wb_ack <= 1'b0;
      if (irq_dly > 0) begin
        irq_dly <= irq_dly - 1;
        if (irq_dly == 1 && irq_en) irq <= 1'b1;
      end
      if (wb_cyc && wb_stb && !wb_ack) begin
        wb_ack <= 1'b1;
        if (wb_we) begin
          wlog.push_back({wb_adr, wb_wdat});
          if (wb_adr == 2'd2) begin
            last_cmd <= wb_wdat;
            irq_dly  <= 3;
            t_cmd    <= cyc_n;
          end
        end else if (wb_adr == 2'd2) begin
          wb_rdat <= (last_cmd == fault_cmd) ? fault_val : 8'h80;
          irq     <= 1'b0;
        end else if (rdq.size() > 0) begin
          wb_rdat <= rdq.pop_front();
        end else begin
          wb_rdat <= 8'hEE;
        end
      end
    end
  end

  logic [7:0] wq[$];
  int         wr_n = 0;

  initial forever begin
    @(negedge clk);
    wdat_valid = (wq.size() > 0);
    wdat = (wq.size() > 0) ? wq[0] : 8'h00;
    #1;
    if (wdat_valid && wdat_ready) begin
      wr_n++;
      @(posedge clk);
      if (wq.size() > 0) void'(wq.pop_front());
    end
  end

  int         rsp_n = 0;
  int         overlap_n = 0;
  int         t_rsp = 0;
  logic [2:0] last_status = '0;
  logic [8:0] rq[$];

  always @(negedge clk) begin
    if (rdat_valid) rq.push_back({rdat_last, rdat});
    if (rsp_valid) begin
      rsp_n++;
      last_status = rsp_status;
      t_rsp = cyc_n;
    end
    if (rsp_valid && req_ready) overlap_n++;
  end

  logic [9:0] elog[$];

  task automatic check_log(input string tag);
    chk({tag, "_wb_count"}, wlog.size(), elog.size());
    for (int i = 0; i < wlog.size() && i < elog.size(); i++)
      chk({tag, "_wb_write"}, {22'd0, wlog[i]}, {22'd0, elog[i]});
    wlog.delete();
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    @(negedge clk);
    while (!req_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk(tag, {31'd0, req_ready}, 1);
  endtask

  task automatic send_req(input logic rd, input logic [6:0] a, input logic [7:0] n);
    wait_idle("req_ready_wait");
    req_rd = rd;
    req_addr = a;
    req_len = n;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int prev);
    int k = 0;
    while (rsp_n == prev && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("rsp_seen", rsp_n - prev, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  int p;
  int d;
  int k;
  logic [8:0] erd[3];

  initial begin
    erd = '{9'h010, 9'h011, 9'h112};
    #12;
    chk("reset_outputs", {11'd0, req_ready, wdat_ready, rdat_valid, rdat_last, rsp_valid, rsp_status,
        wb_cyc, wb_stb, wb_we, wb_adr, wb_wdat}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_idle("init_idle");
    elog = '{10'h0C0};
    check_log("init");

    // zero length: immediate BAD_LEN, no bus traffic
    p = rsp_n;
    send_req(1'b0, 7'h22, 8'd0);
    chk("badlen_next_cycle", {31'd0, rsp_valid}, 1);
    wait_rsp(p);
    chk("badlen_status", last_status, 5);
    elog.delete();
    check_log("badlen");

    // two-byte write
    wq = '{8'h5A, 8'hA5};
    wr_n = 0;
    p = rsp_n;
    send_req(1'b0, 7'h22, 8'd2);
    wait_rsp(p);
    chk("wr_status", last_status, 0);
    chk("wr_ready_pulses", wr_n, 2);
    elog = '{10'h100, 10'h206, 10'h204, 10'h144, 10'h201, 10'h15A, 10'h201, 10'h1A5, 10'h201, 10'h205};
    check_log("wr");

    // three-byte read
    rdq = '{8'h10, 8'h11, 8'h12};
    rq.delete();
    p = rsp_n;
    send_req(1'b1, 7'h22, 8'd3);
    wait_rsp(p);
    chk("rd_status", last_status, 0);
    chk("rd_count", rq.size(), 3);
    for (int i = 0; i < rq.size() && i < 3; i++) chk("rd_byte", {23'd0, rq[i]}, {23'd0, erd[i]});
    elog = '{10'h100, 10'h206, 10'h204, 10'h145, 10'h201, 10'h202, 10'h202, 10'h203, 10'h205};
    check_log("rd");

    // address NAK: Stop, no data bytes
    fault_cmd = 8'h01;
    fault_val = 8'h40;
    wr_n = 0;
    p = rsp_n;
    send_req(1'b0, 7'h22, 8'd2);
    wait_rsp(p);
    chk("nak_status", last_status, 1);
    chk("nak_no_wdat", wr_n, 0);
    elog = '{10'h100, 10'h206, 10'h204, 10'h144, 10'h201, 10'h205};
    check_log("nak");

    // arbitration lost on Start, then a normal write
    fault_cmd = 8'h04;
    fault_val = 8'h20;
    wq = '{8'h77};
    p = rsp_n;
    send_req(1'b0, 7'h22, 8'd1);
    wait_rsp(p);
    chk("al_status", last_status, 2);
    chk("al_byte_kept", wq.size(), 1);
    elog = '{10'h100, 10'h206, 10'h204};
    check_log("al");
    fault_cmd = 8'hFF;
    p = rsp_n;
    send_req(1'b0, 7'h22, 8'd1);
    wait_rsp(p);
    chk("after_al_status", last_status, 0);
    elog = '{10'h100, 10'h206, 10'h204, 10'h144, 10'h201, 10'h177, 10'h201, 10'h205};
    check_log("after_al");

    // AL and NAK together on the address byte: AL wins, no Stop
    fault_cmd = 8'h01;
    fault_val = 8'h60;
    p = rsp_n;
    send_req(1'b1, 7'h22, 8'd1);
    wait_rsp(p);
    chk("al_nak_status", last_status, 2);
    elog = '{10'h100, 10'h206, 10'h204, 10'h145, 10'h201};
    check_log("al_nak");

    // ERR on Set Bus: Stop issued
    fault_cmd = 8'h06;
    fault_val = 8'h10;
    p = rsp_n;
    send_req(1'b0, 7'h22, 8'd1);
    wait_rsp(p);
    chk("err_status", last_status, 3);
    elog = '{10'h100, 10'h206, 10'h205};
    check_log("err");
    fault_cmd = 8'hFF;

    // no irq: timeout after 16 wait cycles, CSR rewritten
    irq_en = 1'b0;
    p = rsp_n;
    send_req(1'b0, 7'h22, 8'd1);
    wait_rsp(p);
    chk("to_status", last_status, 4);
    d = t_rsp - t_cmd;
    chk("to_latency_in_range", {31'd0, (d >= 20 && d <= 24)}, 1);
    elog = '{10'h100, 10'h206, 10'h0C0};
    check_log("to");
    irq_en = 1'b1;

    // reset while the first write byte is on the bus
    wq = '{8'h5A, 8'hA5};
    p = rsp_n;
    send_req(1'b0, 7'h22, 8'd2);
    k = 0;
    while (!(wb_cyc && wb_we && wb_adr == 2'd1 && wb_wdat == 8'h5A) && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("rst_found_byte1", {31'd0, (k < 300)}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_cyc_stb", {30'd0, wb_cyc, wb_stb}, 0);
    wq.delete();
    rdq.delete();
    wlog.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_idle("rst_reinit_idle");
    elog = '{10'h0C0};
    check_log("rst_reinit");
    chk("rst_no_rsp", rsp_n - p, 0);

    chk("rsp_ready_overlap", overlap_n, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
